// File: rtl/sequenciador_pc_if.sv
// Bus between the PC sequencer and its fetch/datapath neighbours.
// master = sequencer side, slave = memory/datapath side.
interface sequenciador_pc_if;
  logic        mem_ack;
  logic        stall;
  logic        sinal_mux;
  logic [31:0] imediato;
  logic        mem_req;
  logic [31:0] endereco_pc;
  logic        pc_we;
  logic        instr_valid;
  logic        erro_alinhamento;
  logic [31:0] contador_instr;
  logic [2:0]  fase;

  modport master (
    input  mem_ack, stall, sinal_mux, imediato,
    output mem_req, endereco_pc, pc_we, instr_valid,
    output erro_alinhamento, contador_instr, fase
  );

  modport slave (
    output mem_ack, stall, sinal_mux, imediato,
    input  mem_req, endereco_pc, pc_we, instr_valid,
    input  erro_alinhamento, contador_instr, fase
  );
endinterface

// File: rtl/sequenciador_pc.sv
// Multicycle fetch/PC sequencer: fetch, decode, execute, update.
// Owns the PC, retired-instruction count and misalignment flag.
module sequenciador_pc #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input logic               clock,
  input logic               reset,
  sequenciador_pc_if.master bus
);

  typedef enum logic [2:0] {
    INICIO     = 3'b000,
    BUSCA      = 3'b001,
    DECODIFICA = 3'b010,
    EXECUTA    = 3'b011,
    ATUALIZA   = 3'b100,
    ERRO       = 3'b101
  } fase_e;

  fase_e       state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        salto_q, salto_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] alvo;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INICIO;
      pc_q    <= RESET_ADDR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      salto_q <= 1'b0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      salto_q <= salto_d;
      imm_q   <= imm_d;
    end
  end

  assign alvo = pc_q + bus.imediato;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    salto_d = salto_q;
    imm_d   = imm_q;
    case (state_q)
      INICIO:     state_d = BUSCA;
      BUSCA:      if (bus.mem_ack) state_d = DECODIFICA;
      DECODIFICA: state_d = EXECUTA;
      EXECUTA: begin
        if (!bus.stall) begin
          salto_d = bus.sinal_mux;
          imm_d   = bus.imediato;
          // Misaligned taken target: trap without touching PC/count
          if (bus.sinal_mux && (alvo[1:0] != 2'b00)) begin
            state_d = ERRO;
            err_d   = 1'b1;
          end else begin
            state_d = ATUALIZA;
          end
        end
      end
      ATUALIZA: begin
        pc_d    = salto_q ? (pc_q + imm_q) : (pc_q + 32'd4);
        cnt_d   = cnt_q + 32'd1;
        state_d = BUSCA;
      end
      ERRO:       state_d = ERRO;
      default:    state_d = INICIO;
    endcase
  end

  assign bus.mem_req          = (state_q == BUSCA);
  assign bus.instr_valid      = (state_q == DECODIFICA);
  assign bus.pc_we            = (state_q == ATUALIZA);
  assign bus.endereco_pc      = pc_q;
  assign bus.contador_instr   = cnt_q;
  assign bus.erro_alinhamento = err_q;
  assign bus.fase             = state_q;

endmodule

// File: tb/tb_sequenciador_pc.sv
// Randomized self-checking bench for sequenciador_pc against an
// instruction-level model (PC/count updated once per instruction).
module tb_sequenciador_pc;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] mpc;
  logic [31:0] mcnt;

  sequenciador_pc_if bus ();

  sequenciador_pc #(.RESET_ADDR(32'h0)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check_eq("rst_fase", 32'(bus.fase), 32'd0);
      check_eq("rst_pc", bus.endereco_pc, 32'h0);
      check_eq("rst_req", 32'(bus.mem_req), 32'd0);
      check_eq("rst_cnt", bus.contador_instr, 32'd0);
      check_eq("rst_err", 32'(bus.erro_alinhamento), 32'd0);
    end
    reset = 1'b0;
    mpc   = 32'h0;
    mcnt  = 32'h0;
    tick();
    check_eq("rel_req", 32'(bus.mem_req), 32'd1);
    check_eq("rel_fase", 32'(bus.fase), 32'd1);
  endtask

  // One instruction from a BUSCA cycle; returns 1 if it trapped.
  task automatic run_instr(input int w, input int s, input logic br,
                           input logic [31:0] imm, output bit trap);
    logic [31:0] tgt;
    trap = 1'b0;
    check_eq("bus_fase", 32'(bus.fase), 32'd1);
    for (int c = 0; c <= w; c++) begin
      check_eq("bus_req", 32'(bus.mem_req), 32'd1);
      check_eq("bus_pc", bus.endereco_pc, mpc);
      bus.mem_ack   = (c == w);
      bus.stall     = 1'($urandom);
      bus.sinal_mux = 1'($urandom);
      tick();
    end
    check_eq("dec_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("dec_req", 32'(bus.mem_req), 32'd0);
    bus.mem_ack = 1'($urandom);
    bus.stall   = 1'($urandom);
    tick();
    for (int c = 0; c <= s; c++) begin
      check_eq("exe_fase", 32'(bus.fase), 32'd3);
      check_eq("exe_we", 32'(bus.pc_we), 32'd0);
      bus.mem_ack   = 1'($urandom);
      bus.stall     = (c < s);
      bus.sinal_mux = (c == s) ? br : 1'($urandom);
      bus.imediato  = (c == s) ? imm : $urandom;
      tick();
    end
    bus.mem_ack = 1'b0;
    tgt = mpc + imm;
    if (br && tgt[1:0] != 2'b00) begin
      trap = 1'b1;
      check_eq("trap_fase", 32'(bus.fase), 32'd5);
      check_eq("trap_err", 32'(bus.erro_alinhamento), 32'd1);
      check_eq("trap_pc", bus.endereco_pc, mpc);
      check_eq("trap_cnt", bus.contador_instr, mcnt);
      check_eq("trap_req", 32'(bus.mem_req), 32'd0);
    end else begin
      check_eq("upd_we", 32'(bus.pc_we), 32'd1);
      check_eq("upd_pc_old", bus.endereco_pc, mpc);
      tick();
      mpc  = br ? tgt : mpc + 32'd4;
      mcnt = mcnt + 32'd1;
      check_eq("nxt_fase", 32'(bus.fase), 32'd1);
      check_eq("nxt_pc", bus.endereco_pc, mpc);
      check_eq("nxt_cnt", bus.contador_instr, mcnt);
      check_eq("nxt_we", 32'(bus.pc_we), 32'd0);
      check_eq("nxt_err", 32'(bus.erro_alinhamento), 32'd0);
    end
  endtask

  initial begin
    bit trap;
    bus.mem_ack   = 1'b0;
    bus.stall     = 1'b0;
    bus.sinal_mux = 1'b0;
    bus.imediato  = 32'h0;

    do_reset(3);

    for (int i = 0; i < 3; i++) run_instr(0, 0, 1'b0, 32'h0, trap);
    check_eq("seq_cnt", bus.contador_instr, 32'd3);
    check_eq("seq_pc", bus.endereco_pc, 32'd12);

    run_instr(3, 2, 1'b0, 32'h40, trap);

    do_reset(1);
    run_instr(0, 0, 1'b0, 32'h0, trap);
    run_instr(0, 0, 1'b0, 32'h0, trap);
    run_instr(0, 0, 1'b1, 32'hFFFF_FFF8, trap);
    check_eq("br_back", bus.endereco_pc, 32'h0);
    run_instr(1, 1, 1'b1, 32'hFFFF_FFFC, trap);
    check_eq("br_neg", bus.endereco_pc, 32'hFFFF_FFFC);
    run_instr(0, 0, 1'b1, 32'h8, trap);
    check_eq("br_wrap", bus.endereco_pc, 32'h4);

    run_instr(0, 1, 1'b1, 32'h2, trap);
    check_eq("mis_trap", 32'(trap), 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.mem_ack = 1'b1;
      tick();
      check_eq("erro_req", 32'(bus.mem_req), 32'd0);
      check_eq("erro_fase", 32'(bus.fase), 32'd5);
      check_eq("erro_pc", bus.endereco_pc, 32'h4);
      check_eq("erro_we", 32'(bus.pc_we), 32'd0);
    end
    bus.mem_ack = 1'b0;
    do_reset(1);

    run_instr(0, 0, 1'b0, 32'h0, trap);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    bus.stall     = 1'b1;
    bus.sinal_mux = 1'b1;
    bus.imediato  = 32'h8;
    tick();
    check_eq("mid_fase", 32'(bus.fase), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.stall     = 1'b0;
    bus.sinal_mux = 1'b0;
    mpc  = 32'h0;
    mcnt = 32'h0;
    check_eq("mid_we", 32'(bus.pc_we), 32'd0);
    check_eq("mid_fase0", 32'(bus.fase), 32'd0);
    check_eq("mid_pc", bus.endereco_pc, 32'h0);
    check_eq("mid_cnt", bus.contador_instr, 32'd0);
    tick();
    check_eq("mid_req", 32'(bus.mem_req), 32'd1);
    run_instr(0, 0, 1'b0, 32'h0, trap);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] imm;
      logic        br;
      br  = 1'($urandom);
      imm = ($urandom_range(0, 7) == 0) ? $urandom
                                        : ($urandom & 32'hFFFF_FFFC);
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), br, imm, trap);
      if (trap) begin
        tick();
        check_eq("rnd_erro", 32'(bus.fase), 32'd5);
        do_reset($urandom_range(1, 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sequenciador_pc.md
# sequenciador_pc

Multicycle fetch/PC sequencer for the RV32 core. It owns the program counter value driven into the PC register's `endereco_pc` input and steps it through fetch, decode, execute and update phases. It handshakes with instruction memory, holds on datapath stalls, and selects PC+4 or PC+imediato from the branch-condition signal `sinal_mux`. It also flags misaligned branch targets and counts retired instructions.

## Interface
- `RESET_ADDR`, default 32'h0000_0000: PC value after reset; must be 4-byte aligned.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; has priority over every other input.
- `mem_ack`  in  1  instruction memory data valid; sampled only in BUSCA.
- `stall`  in  1  datapath hold request; sampled only in EXECUTA.
- `sinal_mux`  in  1  branch taken (branch AND zero); sampled on EXECUTA exit.
- `imediato`  in  32  branch offset, two's complement; sampled with `sinal_mux`.
- `mem_req`  out  1  instruction fetch request at address `endereco_pc`.
- `endereco_pc`  out  32  current PC, registered.
- `pc_we`  out  1  one-cycle pulse; the PC changes at the end of this cycle.
- `instr_valid`  out  1  fetched instruction is valid for decode.
- `erro_alinhamento`  out  1  sticky misaligned-target flag.
- `contador_instr`  out  32  retired-instruction count, registered.
- `fase`  out  3  current state encoding, for debug and verification.

## Operation
- States and encodings:
  - INICIO = 000
  - BUSCA = 001
  - DECODIFICA = 010
  - EXECUTA = 011
  - ATUALIZA = 100
  - ERRO = 101
  - Encodings 110 and 111 are illegal and go to INICIO on the next edge.
- Outputs are Moore decodes of state, except the registered `endereco_pc`, `contador_instr` and `erro_alinhamento`:
  - `mem_req` = 1 only in BUSCA.
  - `instr_valid` = 1 only in DECODIFICA.
  - `pc_we` = 1 only in ATUALIZA.
- INICIO → BUSCA unconditionally when `reset` = 0.
- BUSCA:
  - Stays in BUSCA while `mem_ack` = 0; there is no timeout.
  - Goes to DECODIFICA on the edge where `mem_ack` = 1.
- DECODIFICA → EXECUTA unconditionally; it always lasts exactly 1 cycle.
- EXECUTA:
  - Stays in EXECUTA while `stall` = 1.
  - When `stall` = 0, latches `sinal_mux` and `imediato` into internal registers `salto_r` and `imm_r`.
  - Computes `alvo` = `endereco_pc` + `imediato`, 32-bit, modulo 2^32.
  - If `sinal_mux` = 1 and `alvo[1:0]` ≠ 00: goes to ERRO, sets `erro_alinhamento`, leaves the PC unchanged and does not increment the counter.
  - Otherwise goes to ATUALIZA.
- ATUALIZA:
  - `endereco_pc` <= `salto_r` ? `endereco_pc` + `imm_r` : `endereco_pc` + 4; both sums wrap modulo 2^32.
  - `contador_instr` += 1, wrapping modulo 2^32.
  - Then → BUSCA.
- ERRO: absorbing state. All request and strobe outputs are 0 and the PC is held; only `reset` exits it.
- The not-taken path can never misalign, because `RESET_ADDR` is aligned and +4 preserves alignment.
- `mem_ack` outside BUSCA, and `stall` outside EXECUTA, are ignored.

## Timing
- Reset, on any edge with `reset` = 1:
  - state = INICIO, `endereco_pc` = `RESET_ADDR`, `contador_instr` = 0, `erro_alinhamento` = 0.
  - `mem_req`, `instr_valid` and `pc_we` are all 0.
- Reset mid-instruction, in any state including ERRO, aborts the instruction. It discards the latched `salto_r`/`imm_r` and produces no `pc_we`.
- First `mem_req` = 1 appears 1 cycle after `reset` falls (INICIO occupies one cycle).
- Minimum instruction period is 4 cycles: BUSCA with same-cycle `mem_ack`, then DECODIFICA, EXECUTA with `stall` = 0, then ATUALIZA.
  - Each cycle of `mem_ack` wait adds 1 cycle.
  - Each cycle of `stall` adds 1 cycle.
- Fetch handshake: `mem_req` stays high and `endereco_pc` stays stable until the `mem_ack` edge. `mem_req` drops in the cycle after that edge.
- The new PC is visible on `endereco_pc` in the cycle after ATUALIZA, coincident with the next BUSCA.
- Branch decision:
  - Uses the `sinal_mux`/`imediato` values present on the EXECUTA exit edge.
  - Changes to these inputs during stall cycles before that edge have no effect.
- `erro_alinhamento` rises in the first ERRO cycle and holds until reset.

## Test plan
- **Reset release:** hold `reset` 3 cycles, then drop it, with `RESET_ADDR` = 0.
  - While `reset` is held: `fase` = 000, `endereco_pc` = 0, `mem_req` = 0.
  - The next cycle: `mem_req` = 1.
- **Sequential fetch:** `mem_ack` tied 1, `stall` 0, `sinal_mux` 0, run 12 cycles.
  - `endereco_pc` steps 0→4→8 every 4 cycles.
  - `pc_we` pulses once per 4 cycles.
  - `contador_instr` = 3.
- **Wait states and stall:** `mem_ack` delayed 3 cycles, `stall` high 2 cycles.
  - Instruction period is 4+3+2 = 9 cycles.
  - `mem_req` is high for 4 consecutive cycles.
  - Toggling `sinal_mux` during the stall does not change the outcome.
- **Taken branch:** PC = 8, `sinal_mux` = 1, `imediato` = 32'hFFFF_FFF8 (−8).
  - The next PC is 0.
  - With PC = 32'hFFFF_FFFC and `imediato` = 8, the next PC is 4 (wrap).
- **Misaligned target:** PC = 4, `sinal_mux` = 1, `imediato` = 2.
  - `fase` = 101 and `erro_alinhamento` = 1.
  - `endereco_pc` stays 4 and `contador_instr` is unchanged.
  - `mem_req` stays 0 for 10 cycles; a reset then clears the error.
- **Reset mid-EXECUTA:** assert `reset` while in EXECUTA with a taken branch pending.
  - No `pc_we` is produced.
  - `endereco_pc` = `RESET_ADDR` and `contador_instr` = 0.
